// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: widths, ALU in_sel codes,
// sequencer state encoding and the one-hot operation check.
package alu_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int OP_W_DEF   = 7;

    localparam logic [2:0] IN_SEL_PERSIST = 3'b100;
    localparam logic [2:0] IN_SEL_LOAD    = 3'b010;
    localparam logic [2:0] IN_SEL_RESET   = 3'b001;
    localparam logic [2:0] IN_SEL_NOP     = 3'b000;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HOLD  = 3'd4
    } seq_state_e;

    // Exactly one bit set; callers zero-extend their operation field.
    function automatic logic is_onehot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command buffer for the ALU sequencer: synchronous FIFO, registered count,
// pointers wrap modulo DEPTH (DEPTH is a power of two).
module alu_cmd_fifo #(
    parameter int WIDTH = 23,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Full is judged on the registered count, so a pop in the same cycle
    // does not make room for a push.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Feeds buffered operand/operation commands to the 8-bit ALU one at a time,
// waits the ALU latency, and holds each result on a valid/ready port.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OP_W   = OP_W_DEF,
    parameter int DEPTH  = 4,
    parameter int LAT    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [OP_W-1:0]   cmd_op,
    output logic              alu_on,
    output logic [2:0]        alu_in_sel,
    output logic [DATA_W-1:0] alu_num1,
    output logic [DATA_W-1:0] alu_num2,
    output logic [OP_W-1:0]   alu_out_sel,
    input  logic [DATA_W-1:0] alu_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [OP_W-1:0]   res_op,
    output logic              res_err,
    output logic              busy
);

    localparam int FIFO_W = 2 * DATA_W + OP_W;
    localparam int FCNT_W = $clog2(DEPTH) + 1;
    localparam int CNT_W  = (LAT > 1) ? $clog2(LAT) : 1;

    seq_state_e        state_q, state_d;
    logic              init_done_q;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0] num1_q, num2_q;
    logic [OP_W-1:0]   out_sel_q;
    logic [DATA_W-1:0] res_data_q;
    logic [OP_W-1:0]   res_op_q;
    logic              res_err_q;

    logic [FIFO_W-1:0] head;
    logic [DATA_W-1:0] head_a, head_b;
    logic [OP_W-1:0]   head_op;
    logic              fifo_full, fifo_empty;
    logic [FCNT_W-1:0] fifo_count;
    logic              fifo_pop;
    logic              op_ok;

    alu_cmd_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (DEPTH),
        .CNT_W (FCNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (cmd_valid && cmd_ready),
        .wdata_i ({cmd_a, cmd_b, cmd_op}),
        .pop_i   (fifo_pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign {head_a, head_b, head_op} = head;
    assign op_ok       = is_onehot(32'(out_sel_q));
    assign fifo_pop    = (state_q == ST_ISSUE);
    assign res_valid   = (state_q == ST_HOLD);
    assign alu_num1    = num1_q;
    assign alu_num2    = num2_q;
    assign alu_out_sel = out_sel_q;
    assign res_data    = res_data_q;
    assign res_op      = res_op_q;
    assign res_err     = res_err_q;

    // INIT spans two phases: before the first edge after reset release the
    // ALU stays off; init_done_q then gives exactly one ALU reset cycle.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        alu_on     = 1'b0;
        alu_in_sel = IN_SEL_NOP;
        cmd_ready  = !fifo_full;
        busy       = (fifo_count != '0);
        case (state_q)
            ST_INIT: begin
                alu_on     = init_done_q;
                alu_in_sel = IN_SEL_RESET;
                cmd_ready  = 1'b0;
                busy       = init_done_q;
                if (init_done_q) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                busy = 1'b1;
                if (op_ok) begin
                    alu_on     = 1'b1;
                    alu_in_sel = IN_SEL_LOAD;
                    wait_cnt_d = CNT_W'(LAT - 1);
                    state_d    = ST_WAIT;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_WAIT: begin
                busy       = 1'b1;
                alu_on     = 1'b1;
                alu_in_sel = IN_SEL_PERSIST;
                if (wait_cnt_q == '0) begin
                    state_d = ST_HOLD;
                end else begin
                    wait_cnt_d = wait_cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                busy = 1'b1;
                if (res_ready) begin
                    state_d = fifo_empty ? ST_IDLE : ST_ISSUE;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_INIT;
            init_done_q <= 1'b0;
            wait_cnt_q  <= '0;
            num1_q      <= '0;
            num2_q      <= '0;
            out_sel_q   <= '0;
            res_data_q  <= '0;
            res_op_q    <= '0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_done_q <= 1'b1;
            wait_cnt_q  <= wait_cnt_d;
            // ISSUE is never re-entered from itself, and no pop happens on
            // the entry edge, so the head here is the command being issued.
            if (state_d == ST_ISSUE) begin
                num1_q    <= head_a;
                num2_q    <= head_b;
                out_sel_q <= head_op;
            end
            if (state_q == ST_ISSUE && !op_ok) begin
                res_data_q <= '0;
                res_op_q   <= out_sel_q;
                res_err_q  <= 1'b1;
            end else if (state_q == ST_WAIT && wait_cnt_q == '0) begin
                res_data_q <= alu_out;
                res_op_q   <= out_sel_q;
                res_err_q  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Upstream command stage for the 8-bit ALU (`main`). It accepts operand/operation commands over a valid/ready handshake and buffers them in a small FIFO. It drives the ALU's on/in_sel/num1/num2/out_sel inputs one operation at a time, waits a fixed latency, then captures `out` and presents it on a valid/ready result port. This replaces hand-sequencing of ALU inputs in benches and in the top level.

Parameters:
DATA_W, 8, operand/result width (matches ALU num1/num2/out)
OP_W, 7, one-hot operation select width (matches ALU out_sel)
DEPTH, 4, command FIFO depth; power of two, >=2
LAT, 2, ALU cycles from end of ISSUE to valid `out`; >=1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command FIFO can accept (= !full)
cmd_a  in  DATA_W  operand 1
cmd_b  in  DATA_W  operand 2
cmd_op  in  OP_W  one-hot operation select
alu_on  out  1  to ALU `on`
alu_in_sel  out  3  to ALU in_sel {persist,load,reset}
alu_num1  out  DATA_W  to ALU num1
alu_num2  out  DATA_W  to ALU num2
alu_out_sel  out  OP_W  to ALU out_sel
alu_out  in  DATA_W  from ALU out
res_valid  out  1  result held
res_ready  in  1  result consumer accepts
res_data  out  DATA_W  captured ALU result
res_op  out  OP_W  operation that produced res_data
res_err  out  1  1 = cmd_op was not one-hot; res_data = 0
busy  out  1  state != IDLE or FIFO non-empty

Behaviour:
- in_sel encodings: PERSIST=3'b100, LOAD=3'b010, RESET=3'b001, NOP=3'b000.
- Reset (rst=0, async): FIFO emptied, state=INIT, alu_on=0, alu_in_sel=RESET, alu_num1/num2/out_sel=0, res_valid=0, res_data=0, res_op=0, res_err=0, cmd_ready=0, busy=0.
- FSM states: INIT, IDLE, ISSUE, WAIT, HOLD.
- INIT: lasts exactly one cycle after rst releases. alu_on=1, in_sel=RESET. Goes to IDLE. cmd_ready=0 in INIT only.
- IDLE: alu_on=0, in_sel=NOP. Goes to ISSUE when the FIFO is non-empty (registered count; a command pushed at edge k is issued from edge k+1).
- ISSUE: one cycle. alu_on=1, in_sel=LOAD, num1/num2/out_sel = FIFO head. FIFO pops at the end of the cycle.
  - Head op not one-hot (zero or multiple bits): no ALU load (in_sel=NOP, alu_on=0); next state HOLD with res_err=1, res_data=0, res_op=head op.
  - Otherwise: load wait counter with LAT-1; go to WAIT.
- WAIT: alu_on=1, in_sel=PERSIST, num1/num2/out_sel held. Counter decrements each cycle. At the edge where counter==0, capture res_data<=alu_out, res_op, res_err=0, and go to HOLD.
- HOLD: res_valid=1; res_data/op/err stable until the handshake. ALU outputs as in IDLE.
  - On res_valid&&res_ready: go to ISSUE if the FIFO is non-empty, else IDLE. res_valid drops at that edge.
- Latency: cmd accepted at edge k into an empty, idle block -> res_valid high after edge k+2+LAT. Back-to-back throughput with res_ready=1 is one result per LAT+2 cycles.
- FIFO: push when cmd_valid&&cmd_ready. Same-cycle push and pop are legal; count is unchanged.
  - cmd_ready derives from registered count, so a full FIFO rejects a push even if a pop occurs that cycle.
  - Pointers wrap modulo DEPTH.
  - Ordering is strict FIFO; results emerge in command order.
- cmd_valid while cmd_ready=0: the command is not taken; no state change. The source must hold it.
- Reset mid-operation: in-flight op and buffered commands are discarded; no result is emitted; restarts at INIT.
- ALU inputs change only on the ISSUE entry edge and are constant through WAIT.

Decomposition:
- Package alu_pkg:
  - DATA_W/OP_W defaults
  - in_sel constants PERSIST/LOAD/RESET/NOP
  - 3-bit state enum (INIT, IDLE, ISSUE, WAIT, HOLD)
  - one-hot check function
- Sub-module alu_cmd_fifo:
  - synchronous FIFO with async active-low reset
  - parameters WIDTH=2*DATA_W+OP_W and DEPTH
  - outputs full/empty/count
- Top contains the FSM, wait counter, and result register.

Test Plan:
- Reset/INIT: hold rst=0 5 cycles, release -> one cycle alu_on=1, alu_in_sel=001; then IDLE with alu_in_sel=000, res_valid=0, cmd_ready=1.
- Single op (bench ALU stub returns num1+num2 after LAT): cmd a=0x57, b=0x1A, op=7'b1000000 at edge k.
  - ISSUE drives in_sel=010 and num1=0x57.
  - res_valid rises after edge k+4 with res_data=0x71, res_op=7'b1000000, res_err=0.
- Invalid op: cmd op=7'b0000011 -> alu_on never asserted for it; res_valid with res_err=1, res_data=0x00, res_op=7'b0000011.
- Full/backpressure: hold res_ready=0 and push 6 commands with ops 7'b1000000 down to 7'b0000010.
  - Exactly 5 are taken: 1 in flight plus DEPTH=4 buffered; cmd_ready=0 thereafter.
  - Releasing res_ready drains results in push order.
- Back-to-back: res_ready=1, 3 commands queued -> results spaced exactly LAT+2=4 cycles apart; busy falls one cycle after the last handshake.
- Mid-op reset: assert rst=0 during WAIT with 2 commands buffered -> res_valid=0 immediately; after release, no stale result, FIFO empty, busy=0.
